shift_add_multiplier: RTL and testbench

//  Unsigned sequential multiplier; the multiply counterpart of the restoring-divider datapath.
//  Has an internal product register, an adder with a carry-out and a control FSM.

---
 rtl/shift_add_multiplier.sv | 107 ++++++++++
 tb/tb_shift_add_multiplier.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// Unsigned sequential shift-right/add multiplier: one multiplier bit per clock,
// WIDTH iterations, start/done handshake matching the restoring divider.
`timescale 1ns/1ps

module shift_add_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     Multiplicand_in,
    input  logic [WIDTH-1:0]     Multiplier_in,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   Product,
    output logic [1:0]           dbg_state_o
);

    // Handshake: start is sampled only in IDLE; the edge that sees it high
    // captures both operands and raises busy. busy stays high for exactly
    // WIDTH cycles, then done pulses for one cycle with Product final.
    // start in CALC or DONE is ignored; Product holds until the next accept.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    state_e               state_q,   state_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic [WIDTH-1:0]     mcand_q,   mcand_d;
    logic [CW-1:0]        count_q,   count_d;
    logic                 busy_q,    busy_d;
    logic                 done_q,    done_d;

    logic [WIDTH-1:0]     addend;
    logic [WIDTH:0]       sum_ext;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            product_q <= '0;
            mcand_q   <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            product_q <= product_d;
            mcand_q   <= mcand_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        product_d = product_q;
        mcand_d   = mcand_q;
        count_d   = count_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        // Full W+1-bit sum so the carry-out lands in the product MSB.
        addend  = product_q[0] ? mcand_q : '0;
        sum_ext = {1'b0, product_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};

        case (state_q)
            IDLE: begin
                if (start) begin
                    product_d = {{WIDTH{1'b0}}, Multiplier_in};
                    mcand_d   = Multiplicand_in;
                    count_d   = '0;
                    busy_d    = 1'b1;
                    state_d   = CALC;
                end
            end
            CALC: begin
                product_d = {sum_ext, product_q[WIDTH-1:1]};
                count_d   = count_q + CW'(1);
                if (count_q == LAST_ITER) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign Product     = product_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed and random checks of shift_add_multiplier: latency, carry path,
// zero operands, ignored start, mid-operation reset and back-to-back starts.
`timescale 1ns/1ps

module tb_shift_add_multiplier;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           Reset = 1'b1;
    logic           start = 1'b0;
    logic [W-1:0]   mcand_in = '0;
    logic [W-1:0]   mplier_in = '0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;
    logic [1:0]     dbg_state;

    int checks = 0;
    int failures = 0;
    logic [2*W-1:0] exp_q[$];

    shift_add_multiplier #(.WIDTH(W)) dut (
        .clk             (clk),
        .Reset           (Reset),
        .start           (start),
        .Multiplicand_in (mcand_in),
        .Multiplier_in   (mplier_in),
        .busy            (busy),
        .done            (done),
        .Product         (product),
        .dbg_state_o     (dbg_state)
    );

    always #5 clk = ~clk;

    // busy and done must never be high together.
    always @(negedge clk) begin
        if (!Reset) begin
            checks++;
            if (busy && done) begin
                failures++;
                $display("FAIL busy_done_overlap: busy=%0b done=%0b required not both 1", busy, done);
            end
        end
    end

    // Driver: launch one op, drop start, wait (bounded) for done.
    // lat counts negedges after the accepting edge; busy_cnt counts busy-high ones.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [2*W-1:0] p, output int lat, output int busy_cnt,
                         output bit timed_out);
        @(negedge clk);
        mcand_in  = a;
        mplier_in = b;
        start     = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        lat      = 1;
        busy_cnt = busy ? 1 : 0;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
            if (busy) busy_cnt++;
        end
        timed_out = !done;
        p = product;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (product !== 64'd0) begin failures++; $display("FAIL reset_product: got %h required 0", product); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", busy); end
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b required 0", done); end
        Reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 64'd0) begin
            failures++;
            $display("FAIL idle_after_reset: busy=%b done=%b product=%h required 0/0/0", busy, done, product);
        end
    endtask

    task automatic test_basic();
        logic [2*W-1:0] p;
        int lat, bc;
        bit to;
        do_op(32'd7, 32'd9, p, lat, bc, to);
        checks++;
        if (to || lat != 33) begin failures++; $display("FAIL basic_latency: got %0d required 33 (timeout=%0b)", lat, to); end
        checks++;
        if (bc != 32) begin failures++; $display("FAIL basic_busy_cycles: got %0d required 32", bc); end
        checks++;
        if (p !== 64'd63) begin failures++; $display("FAIL basic_product: got %h required %h", p, 64'd63); end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || product !== 64'd63) begin
            failures++;
            $display("FAIL basic_hold: done=%b product=%h required 0/%h", done, product, 64'd63);
        end
    endtask

    task automatic test_all_ones();
        logic [2*W-1:0] p;
        int lat, bc;
        bit to;
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, p, lat, bc, to);
        checks++;
        if (to || p !== 64'hFFFF_FFFE_0000_0001) begin
            failures++;
            $display("FAIL all_ones_product: got %h required %h (timeout=%0b)", p, 64'hFFFF_FFFE_0000_0001, to);
        end
        @(negedge clk);
    endtask

    task automatic test_zero();
        logic [2*W-1:0] p;
        int lat, bc;
        bit to;
        do_op(32'h0001_0000, 32'd0, p, lat, bc, to);
        checks++;
        if (to || lat != 33 || p !== 64'd0) begin
            failures++;
            $display("FAIL zero_multiplier: lat=%0d product=%h required 33/0", lat, p);
        end
        @(negedge clk);
        do_op(32'd0, 32'h1234, p, lat, bc, to);
        checks++;
        if (to || lat != 33 || p !== 64'd0) begin
            failures++;
            $display("FAIL zero_multiplicand: lat=%0d product=%h required 33/0", lat, p);
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_start();
        int done_cnt = 0;
        logic [2*W-1:0] p = '0;
        @(negedge clk);
        mcand_in = 32'd3; mplier_in = 32'd5; start = 1'b1;
        for (int n = 1; n <= 50; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == 10) begin mcand_in = 32'd100; mplier_in = 32'd100; start = 1'b1; end
            if (done) begin done_cnt++; p = product; end
        end
        checks++;
        if (done_cnt != 1) begin failures++; $display("FAIL ignore_start_pulses: got %0d required 1", done_cnt); end
        checks++;
        if (p !== 64'd15) begin failures++; $display("FAIL ignore_start_product: got %h required %h", p, 64'd15); end
    endtask

    task automatic test_reset_midop();
        int done_cnt = 0;
        logic [2*W-1:0] p;
        int lat, bc;
        bit to;
        @(negedge clk);
        mcand_in = 32'd11; mplier_in = 32'd13; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        #2 Reset = 1'b1;
        #1;
        checks++;
        if (product !== 64'd0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL midop_reset: product=%h busy=%b done=%b required 0/0/0", product, busy, done);
        end
        @(negedge clk);
        Reset = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        checks++;
        if (done_cnt != 0) begin failures++; $display("FAIL midop_no_done: got %0d pulses required 0", done_cnt); end
        do_op(32'd6, 32'd7, p, lat, bc, to);
        checks++;
        if (to || p !== 64'd42) begin failures++; $display("FAIL midop_next_op: got %h required %h", p, 64'd42); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int d1 = 0, d2 = 0, n = 0;
        logic [2*W-1:0] p1 = '0, p2 = '0;
        @(negedge clk);
        mcand_in = 32'd2; mplier_in = 32'd3; start = 1'b1;
        @(negedge clk);
        mcand_in = 32'd4; mplier_in = 32'd5;
        n = 1;
        while (d2 == 0 && n < 150) begin
            @(negedge clk);
            n++;
            if (done) begin
                if (d1 == 0) begin d1 = n; p1 = product; end
                else begin d2 = n; p2 = product; start = 1'b0; end
            end
            if (d1 != 0 && d2 == 0 && n == d1 + 1) begin
                checks++;
                if (product !== 64'd6) begin failures++; $display("FAIL b2b_hold: got %h required %h", product, 64'd6); end
            end
        end
        start = 1'b0;
        checks++;
        if (d1 != 33 || d2 - d1 != 34) begin
            failures++;
            $display("FAIL b2b_spacing: first=%0d gap=%0d required 33/34", d1, d2 - d1);
        end
        checks++;
        if (p1 !== 64'd6 || p2 !== 64'd20) begin
            failures++;
            $display("FAIL b2b_products: got %h,%h required %h,%h", p1, p2, 64'd6, 64'd20);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random();
        logic [2*W-1:0] p, e;
        logic [W-1:0] a, b;
        int lat, bc;
        bit to;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 4))
                0: a = '1;
                1: a = W'($urandom_range(0, 15));
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0: b = '1;
                1: b = W'($urandom_range(0, 15));
                default: b = $urandom;
            endcase
            exp_q.push_back({{W{1'b0}}, a} * {{W{1'b0}}, b});
            do_op(a, b, p, lat, bc, to);
            e = exp_q.pop_front();
            checks++;
            if (to || p !== e) begin
                failures++;
                $display("FAIL random_product: a=%h b=%h got %h required %h", a, b, p, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_all_ones();
        test_zero();
        test_ignore_start();
        test_reset_midop();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
